// File: rtl/rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
// The index-width helper keeps one-bit indices legal when only two requesters exist.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DefNumReq  = 4;
  localparam int DefMaxHold = 4;

  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface rr_arbiter_if #(
  parameter int NUM_REQ = arb_pkg::DefNumReq
);

  localparam int IW = arb_pkg::idxWidth(NUM_REQ);

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               busy;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  busy
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output busy
  );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational rotating-priority selector: search starts at ptr-1, walks downward
// with wrap-around, and checks ptr itself last.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = DefNumReq,
  localparam int IW     = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic [NUM_REQ-1:0] excl_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] rotated;
  logic [IW-1:0]      srcPos;
  int                 selPos;
  logic               found;

  // Rotated bit N-1 maps to ptr-1, so a plain highest-wins scan gives the rotating order
  always_comb begin
    masked  = req_i & ~excl_i;
    rotated = '0;
    srcPos  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      srcPos     = IW'((j + int'(ptr_i)) % NUM_REQ);
      rotated[j] = masked[srcPos];
    end

    found  = 1'b0;
    selPos = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (!found && rotated[j]) begin
        found  = 1'b1;
        selPos = j;
      end
    end

    valid_o = found;
    idx_o   = found ? IW'((selPos + int'(ptr_i)) % NUM_REQ) : '0;
    pick_o  = '0;
    pick_o[idx_o] = found;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter: one-hot grant that persists while its owner requests,
// with a hold budget that forces rotation once others are waiting.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = DefNumReq,
  parameter int MAX_HOLD = DefMaxHold,
  localparam int IW      = idxWidth(NUM_REQ),
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input logic         clock,
  input logic         reset,
  rr_arbiter_if.slave bus
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [HW-1:0]      holdCnt_q, holdCnt_d;

  logic [NUM_REQ-1:0] pickExcl;
  logic [NUM_REQ-1:0] pickGnt;
  logic [IW-1:0]      pickIdx;
  logic               pickValid;
  logic               ownerReq;
  logic               othersReq;

  // While busy the current owner is masked out; on release its bit is already low
  assign pickExcl  = (state_q == BUSY) ? gnt_q : '0;
  assign ownerReq  = |(bus.req & gnt_q);
  assign othersReq = |(bus.req & ~gnt_q);

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .excl_i  (pickExcl),
    .pick_o  (pickGnt),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      holdCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
    end
  end

  // Enable drop outranks release, and release outranks an expiring hold budget
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.en && pickValid) begin
          state_d   = BUSY;
          gnt_d     = pickGnt;
          idx_d     = pickIdx;
          ptr_d     = pickIdx;
          holdCnt_d = HW'(1);
        end
      end
      BUSY: begin
        if (!bus.en || (!ownerReq && !pickValid)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          holdCnt_d = '0;
        end else if (!ownerReq || ((holdCnt_q == HW'(MAX_HOLD)) && othersReq)) begin
          gnt_d     = pickGnt;
          idx_d     = pickIdx;
          ptr_d     = pickIdx;
          holdCnt_d = HW'(1);
        end else if (holdCnt_q != HW'(MAX_HOLD)) begin
          holdCnt_d = holdCnt_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.gnt     = gnt_q;
    bus.gnt_idx = idx_q;
    bus.busy    = (state_q == BUSY);
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Registered round-robin arbiter that extends the combinational 4-bit priority selector (ps4) into a fair, stateful sharing block.
- Shares one resource among NUM_REQ requesters with a one-hot grant.
- A grant persists while its owner keeps requesting, limited by a hold budget that forces rotation when others are waiting.
- Sits between requesting units and a single shared port (bus, functional unit, memory port).

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- MAX_HOLD, 4, maximum consecutive grant cycles for one owner while any other requester is waiting; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; 0 forces the grant to be dropped.
- req  input  NUM_REQ  request vector; bit i is requester i.
- gnt  output  NUM_REQ  registered one-hot grant, or all zeros.
- gnt_idx  output  $clog2(NUM_REQ)  binary index of the current owner; 0 when gnt is 0.
- busy  output  1  1 when in the BUSY state, i.e. gnt is non-zero.

Behaviour:
- Reset values (when reset=1 at a clock edge):
  - gnt=0, gnt_idx=0, busy=0.
  - state=IDLE, hold_cnt=0.
  - ptr=0, so the first search starts at index NUM_REQ-1, matching the ps4 fixed priority where the highest index wins.
  - reset overrides every other input, including mid-grant.
- Latency: req/en sampled at edge t drive gnt after edge t+1. No combinational path from req to gnt.
- Search order:
  - starts at ptr-1 and scans downward, wrapping NUM_REQ-1 after 0.
  - ptr itself is checked last.
  - whenever a grant is issued to index k, ptr := k.
- IDLE:
  - if en & |req: grant the search winner, go to BUSY, hold_cnt := 1.
  - otherwise stay in IDLE with gnt=0.
- BUSY (owner o):
  - en=0: gnt := 0, go to IDLE; ptr unchanged.
  - req[o]=0 (release): re-arbitrate in the same cycle among the remaining requests. If there is a winner, grant it (no idle bubble), hold_cnt := 1. If there is none, go to IDLE with gnt=0.
  - req[o]=1, hold_cnt==MAX_HOLD and another req bit set: forced rotation to the search winner, excluding o; hold_cnt := 1.
  - req[o]=1, otherwise: hold the grant; hold_cnt := min(hold_cnt+1, MAX_HOLD). With no competitors, o keeps the grant indefinitely.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[i]=1 implies req[i] was 1 at the preceding edge.
  - no requester waits more than (NUM_REQ-1)*MAX_HOLD cycles while en=1 and it holds req high.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD+1); it saturates and never wraps.
  - ptr width is $clog2(NUM_REQ); index arithmetic is modulo NUM_REQ.
- Simultaneous events:
  - en=0 takes priority over release and over rotation.
  - release in the same cycle that the hold budget expires is treated as release.

Decomposition:
- Shared package (arb_pkg) holds:
  - state enum {IDLE, BUSY};
  - default NUM_REQ and MAX_HOLD;
  - index-width helper based on $clog2.
- One sub-module, rr_pick: purely combinational rotating priority selector.
  - inputs: req, ptr, exclude mask.
  - outputs: one-hot pick, index, valid.
  - implemented as rotate, fixed-priority select (ps4 style), rotate back.
- rr_arbiter holds the FSM, ptr, hold_cnt and output registers.

Test Plan (NUM_REQ=4, MAX_HOLD=4; a compare-against-model checker flags any mismatch and invariant violation):
1. Reset: reset=1 for 2 cycles with req=1111, en=1 -> gnt=0000, busy=0, gnt_idx=0. Release reset -> next cycle gnt=1000, gnt_idx=3.
2. Lone holder: req=0100 constant for 10 cycles -> gnt=0100 every cycle after the first; no rotation; hold_cnt saturates at 4.
3. Forced rotation: req=1111 constant -> gnt=1000 x4, 0100 x4, 0010 x4, 0001 x4, then 1000 again.
4. Release re-arbitration: owner 0100, then req changes to 1001 -> next cycle gnt=0001 (search starts at index 1), not 1000; no idle cycle.
5. Enable drop: owner 0010, en=0 -> next cycle gnt=0000, busy=0. Then en=1, req=1010 -> gnt=1000 (search from index 0 wraps to 3).
6. Reset mid-grant: owner 0001 with hold_cnt=2, reset=1 for 1 cycle, req=1111 -> gnt=0000 that cycle, then gnt=1000 (ptr restored to 0).
